// File: rtl/tdm_scan_ctrl.sv
// tdm_scan_ctrl: round-robin select sequencer for a 4:1 mux
// with settle-delayed per-channel capture of the mux output.
module tdm_scan_ctrl #(
  parameter int DWELL  = 4,
  parameter int SETTLE = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       stop,
  input  logic [3:0] ch_en,
  input  logic       y_in,
  output logic [1:0] sel,
  output logic       busy,
  output logic [3:0] sample,
  output logic       sample_valid,
  output logic [1:0] sample_ch,
  output logic       frame_done
);

  typedef enum logic {IDLE, SCAN} state_t;

  localparam logic [7:0] LAST = 8'(DWELL - 1);
  localparam logic [7:0] CAP  = 8'(SETTLE);

  state_t     state, state_n;
  logic [7:0] cnt, cnt_n;
  logic [1:0] sel_n, sch_n;
  logic [3:0] sample_n;
  logic       sv_n, fd_n;

  // First enabled channel above cur, wrapping; cur itself last.
  function automatic logic [1:0] next_ch(
    input logic [3:0] en,
    input logic [1:0] cur
  );
    logic [1:0] r;
    logic [1:0] c;
    logic       found;
    r     = cur;
    found = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      c = cur + 2'(k);
      if (!found && en[c]) begin
        r     = c;
        found = 1'b1;
      end
    end
    return r;
  endfunction

  function automatic logic [1:0] top_ch(
    input logic [3:0] en
  );
    logic [1:0] r;
    r = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (en[i]) r = 2'(i);
    end
    return r;
  endfunction

  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    sel_n    = sel;
    sample_n = sample;
    sch_n    = sample_ch;
    sv_n     = 1'b0;
    fd_n     = 1'b0;
    unique case (state)
      IDLE: begin
        if (start && !stop && |ch_en) begin
          state_n = SCAN;
          sel_n   = next_ch(ch_en, 2'd3);
          cnt_n   = 8'd0;
        end
      end
      SCAN: begin
        if (stop) begin
          state_n = IDLE;
          cnt_n   = 8'd0;
        end else begin
          if (cnt == CAP) begin
            sample_n[sel] = y_in;
            sch_n         = sel;
            sv_n          = 1'b1;
            fd_n          = |ch_en && (sel == top_ch(ch_en));
          end
          if (cnt == LAST) begin
            cnt_n = 8'd0;
            if (|ch_en) begin
              sel_n = next_ch(ch_en, sel);
            end else begin
              state_n = IDLE;
            end
          end else begin
            cnt_n = cnt + 8'd1;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= 8'd0;
      sel          <= 2'd0;
      sample       <= 4'd0;
      sample_valid <= 1'b0;
      sample_ch    <= 2'd0;
      frame_done   <= 1'b0;
    end else begin
      state        <= state_n;
      cnt          <= cnt_n;
      sel          <= sel_n;
      sample       <= sample_n;
      sample_valid <= sv_n;
      sample_ch    <= sch_n;
      frame_done   <= fd_n;
    end
  end

  assign busy = (state == SCAN);

endmodule

// File: tb/tb_tdm_scan_ctrl.sv
// tb_tdm_scan_ctrl: randomized bench for tdm_scan_ctrl with a
// behavioural scan model; two instances (4/1 and 1/0 timing).
module tb_tdm_scan_ctrl;

  logic       clk = 1'b0;
  logic       rst, start, stop;
  logic [3:0] ch_en;
  logic [3:0] mux_d;

  logic [1:0] sel0, sel1, sch0, sch1;
  logic       busy0, busy1, sv0, sv1, fd0, fd1;
  logic [3:0] smp0, smp1;
  logic       y0, y1;

  int checks = 0;
  int errors = 0;

  assign y0 = mux_d[sel0];
  assign y1 = mux_d[sel1];

  always #5 clk = ~clk;

  tdm_scan_ctrl #(.DWELL(4), .SETTLE(1)) u0 (
    .clk(clk), .rst(rst), .start(start), .stop(stop),
    .ch_en(ch_en), .y_in(y0), .sel(sel0), .busy(busy0),
    .sample(smp0), .sample_valid(sv0), .sample_ch(sch0),
    .frame_done(fd0)
  );

  tdm_scan_ctrl #(.DWELL(1), .SETTLE(0)) u1 (
    .clk(clk), .rst(rst), .start(start), .stop(stop),
    .ch_en(ch_en), .y_in(y1), .sel(sel1), .busy(busy1),
    .sample(smp1), .sample_valid(sv1), .sample_ch(sch1),
    .frame_done(fd1)
  );

  wire [10:0] got0 = {sel0, busy0, smp0, sv0, sch0, fd0};
  wire [10:0] got1 = {sel1, busy1, smp1, sv1, sch1, fd1};

  // Reference model: channel being dwelt on and cycles spent on it.
  int         dw [2] = '{4, 1};
  int         stt[2] = '{1, 0};
  logic       m_busy[2];
  int         m_t   [2];
  logic [1:0] m_sel [2];
  logic [3:0] m_smp [2];
  logic       m_sv  [2];
  logic [1:0] m_sch [2];
  logic       m_fd  [2];

  function automatic int lowest(input logic [3:0] en);
    for (int i = 0; i < 4; i++) if (en[i]) return i;
    return 0;
  endfunction

  function automatic int highest(input logic [3:0] en);
    for (int i = 3; i >= 0; i--) if (en[i]) return i;
    return 0;
  endfunction

  function automatic int next_up(input logic [3:0] en, input int cur);
    for (int off = 1; off <= 4; off++)
      if (en[(cur + off) % 4]) return (cur + off) % 4;
    return cur;
  endfunction

  function automatic void model_reset();
    for (int k = 0; k < 2; k++) begin
      m_busy[k] = 0; m_t[k] = 0; m_sel[k] = 0; m_smp[k] = 0;
      m_sv[k] = 0; m_sch[k] = 0; m_fd[k] = 0;
    end
  endfunction

  function automatic void model_step(input int k);
    m_sv[k] = 0;
    m_fd[k] = 0;
    if (!m_busy[k]) begin
      if (start && !stop && ch_en != 0) begin
        m_busy[k] = 1;
        m_sel[k]  = 2'(lowest(ch_en));
        m_t[k]    = 0;
      end
    end else if (stop) begin
      m_busy[k] = 0;
      m_t[k]    = 0;
    end else begin
      if (m_t[k] == stt[k]) begin
        m_smp[k][m_sel[k]] = mux_d[m_sel[k]];
        m_sch[k] = m_sel[k];
        m_sv[k]  = 1;
        if (ch_en != 0 && int'(m_sel[k]) == highest(ch_en))
          m_fd[k] = 1;
      end
      if (m_t[k] == dw[k] - 1) begin
        m_t[k] = 0;
        if (ch_en == 0) m_busy[k] = 0;
        else m_sel[k] = 2'(next_up(ch_en, int'(m_sel[k])));
      end else begin
        m_t[k]++;
      end
    end
  endfunction

  function automatic logic [10:0] exp_vec(input int k);
    return {m_sel[k], m_busy[k], m_smp[k], m_sv[k], m_sch[k], m_fd[k]};
  endfunction

  task automatic tick();
    if (!rst) begin
      model_step(0);
      model_step(1);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic hard_reset();
    #2 rst = 1'b1;
    model_reset();
    tick();
    #2 rst = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    ch_en = 4'hF; mux_d = 4'hF;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (6) tick();
    #2 rst = 1'b1;
    model_reset();
    #1;
    checks++;
    if (got0 !== 11'd0) begin
      errors++;
      $display("FAIL reset_async0 got=%h exp=0", got0);
    end
    checks++;
    if (got1 !== 11'd0) begin
      errors++;
      $display("FAIL reset_async1 got=%h exp=0", got1);
    end
    tick();
    #2 rst = 1'b0;
    ch_en = 4'h0;
    for (int c = 0; c < 5; c++) begin
      tick();
      checks++;
      if ({busy0, sel0, sv0, fd0} !== 5'd0) begin
        errors++;
        $display("FAIL reset_idle c=%0d got=%b exp=0",
                 c, {busy0, sel0, sv0, fd0});
      end
    end
  endtask

  task automatic test_full_scan();
    hard_reset();
    ch_en = 4'hF; mux_d = 4'b1110;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      if (c % 4 == 1 && c <= 17) begin
        checks++;
        if (sel0 !== 2'(((c - 1) / 4) % 4)) begin
          errors++;
          $display("FAIL full_sel c=%0d got=%0d exp=%0d",
                   c, sel0, ((c - 1) / 4) % 4);
        end
      end
      checks++;
      if (sv0 !== (c % 4 == 3) || fd0 !== (c == 15 || c == 31)) begin
        errors++;
        $display("FAIL full_pulse c=%0d got=%b%b exp=%b%b", c, sv0, fd0,
                 (c % 4 == 3), (c == 15 || c == 31));
      end
      if (c == 16) begin
        checks++;
        if (smp0 !== 4'b1110) begin
          errors++;
          $display("FAIL full_sample got=%b exp=1110", smp0);
        end
      end
      checks++;
      if (got1 !== exp_vec(1)) begin
        errors++;
        $display("FAIL full_u1 c=%0d got=%h exp=%h", c, got1, exp_vec(1));
      end
      tick();
    end
  endtask

  task automatic test_masked();
    hard_reset();
    ch_en = 4'b1010;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      checks++;
      if (sel0 !== ((((c - 1) / 4) % 2) ? 2'd3 : 2'd1) ||
          fd0 !== (c % 8 == 7) || smp0[0] !== 1'b0 ||
          smp0[2] !== 1'b0) begin
        errors++;
        $display("FAIL masked c=%0d got sel=%0d fd=%b smp=%b", c, sel0,
                 fd0, smp0);
      end
      checks++;
      if (got0 !== exp_vec(0) || got1 !== exp_vec(1)) begin
        errors++;
        $display("FAIL masked_model c=%0d got=%h/%h exp=%h/%h", c, got0,
                 got1, exp_vec(0), exp_vec(1));
      end
      mux_d = 4'($urandom);
      tick();
    end
  endtask

  task automatic test_empty_mask();
    hard_reset();
    ch_en = 4'h0;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 0; c < 4; c++) begin
      checks++;
      if (busy0 !== 1'b0 || busy1 !== 1'b0) begin
        errors++;
        $display("FAIL empty_start c=%0d got=%b%b exp=00", c, busy0, busy1);
      end
      tick();
    end
    ch_en = 4'hF;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    ch_en = 4'h0;
    for (int c = 2; c <= 8; c++) begin
      if (c == 4 || c == 5) begin
        checks++;
        if (busy0 !== (c == 4)) begin
          errors++;
          $display("FAIL empty_drain c=%0d got=%b exp=%b", c, busy0,
                   (c == 4));
        end
      end
      checks++;
      if (got0 !== exp_vec(0) || got1 !== exp_vec(1)) begin
        errors++;
        $display("FAIL empty_model c=%0d got=%h/%h exp=%h/%h", c, got0,
                 got1, exp_vec(0), exp_vec(1));
      end
      tick();
    end
  endtask

  task automatic test_stop();
    hard_reset();
    ch_en = 4'hF; mux_d = 4'($urandom);
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    stop = 1'b1;
    tick();
    stop = 1'b0;
    checks++;
    if (busy0 !== 1'b0 || sv0 !== 1'b0 || sel0 !== 2'd1) begin
      errors++;
      $display("FAIL stop got busy=%b sv=%b sel=%0d exp 0 0 1",
               busy0, sv0, sel0);
    end
    checks++;
    if (got0 !== exp_vec(0) || got1 !== exp_vec(1)) begin
      errors++;
      $display("FAIL stop_model got=%h/%h exp=%h/%h", got0, got1,
               exp_vec(0), exp_vec(1));
    end
    start = 1'b1; stop = 1'b1;
    tick();
    start = 1'b0; stop = 1'b0;
    for (int c = 0; c < 2; c++) begin
      checks++;
      if (busy0 !== 1'b0 || busy1 !== 1'b0) begin
        errors++;
        $display("FAIL start_stop c=%0d got=%b%b exp=00", c, busy0, busy1);
      end
      tick();
    end
  endtask

  task automatic test_mid_reset();
    hard_reset();
    ch_en = 4'hF; mux_d = 4'hF;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (10) tick();
    #2 rst = 1'b1;
    model_reset();
    #1;
    checks++;
    if (smp0 !== 4'd0 || sel0 !== 2'd0 || busy0 !== 1'b0) begin
      errors++;
      $display("FAIL midrst got smp=%b sel=%0d busy=%b exp 0", smp0, sel0,
               busy0);
    end
    tick();
    #2 rst = 1'b0;
    ch_en = 4'b1100;
    start = 1'b1;
    tick();
    start = 1'b0;
    checks++;
    if (sel0 !== 2'd2 || busy0 !== 1'b1) begin
      errors++;
      $display("FAIL restart got sel=%0d busy=%b exp 2 1", sel0, busy0);
    end
    for (int c = 0; c < 20; c++) begin
      mux_d = 4'($urandom);
      tick();
      checks++;
      if (got0 !== exp_vec(0) || got1 !== exp_vec(1)) begin
        errors++;
        $display("FAIL restart_model c=%0d got=%h/%h exp=%h/%h", c, got0,
                 got1, exp_vec(0), exp_vec(1));
      end
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      start = ($urandom % 6 == 0);
      stop  = ($urandom % 40 == 0);
      if ($urandom % 20 == 0) ch_en = 4'($urandom);
      mux_d = 4'($urandom);
      tick();
      checks++;
      if (got0 !== exp_vec(0) || got1 !== exp_vec(1)) begin
        errors++;
        $display("FAIL random c=%0d got=%h/%h exp=%h/%h", c, got0, got1,
                 exp_vec(0), exp_vec(1));
      end
    end
    start = 1'b0;
    stop  = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; stop = 1'b0;
    ch_en = 4'h0; mux_d = 4'h0;
    model_reset();
    tick();
    tick();
    #2 rst = 1'b0;
    tick();
    test_reset();
    test_full_scan();
    test_masked();
    test_empty_mask();
    test_stop();
    test_mid_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/tdm_scan_ctrl.md
# tdm_scan_ctrl

Time-division scan controller for the 4:1 data mux. It drives the mux select lines through the enabled input channels in round-robin order, holding each channel for a fixed dwell time. After a settle delay it captures the mux output bit into a per-channel sample register. It is the sequencing and capture stage around the mux: select lines feed the mux's s1/s0 inputs, and the mux's y output returns on `y_in`.

## Interface

Parameters:
- `DWELL`, default 4: clock cycles spent on each channel; legal range 1..255.
- `SETTLE`, default 1: cycles after a select change before capture; legal range 0..DWELL-1.

Ports:
- `clk`  input  1  single clock; all state updates on the rising edge.
- `rst`  input  1  asynchronous, active-high reset.
- `start`  input  1  one-cycle request to begin continuous scanning.
- `stop`  input  1  request to abort scanning.
- `ch_en`  input  4  channel enable mask; bit i enables mux input i (0=a, 1=b, 2=c, 3=d).
- `y_in`  input  1  mux output y.
- `sel`  output  2  mux select; `sel[1]` drives s1, `sel[0]` drives s0.
- `busy`  output  1  high while scanning.
- `sample`  output  4  latest captured value per channel; bit i belongs to channel i.
- `sample_valid`  output  1  one-cycle pulse per capture.
- `sample_ch`  output  2  channel index of the most recent capture.
- `frame_done`  output  1  one-cycle pulse when the last enabled channel of a pass is captured.

## Operation

- States: IDLE, SCAN. The dwell counter `cnt` is 8 bits and counts 0..DWELL-1 in SCAN.
- Reset (`rst`=1, asynchronous) forces:
  - state=IDLE, `cnt`=0
  - `sel`=0, `busy`=0, `sample`=0
  - `sample_valid`=0, `sample_ch`=0, `frame_done`=0
- Leaving IDLE: requires `start`=1, `stop`=0 and `ch_en`!=0.
  - Next state is SCAN, with `sel` = lowest enabled index, `cnt`=0, `busy`=1.
  - `start` with `ch_en`=0 is ignored.
- In SCAN, each cycle:
  - `stop`=1: go to IDLE next edge. `busy`=0 and `cnt`=0; `sel` and `sample` hold; no capture that edge. `stop` has priority over capture and advance.
  - `cnt`==SETTLE: on that edge, `sample[sel]`<=`y_in`, `sample_ch`<=`sel`, `sample_valid`<=1.
  - `frame_done`<=1 on the same edge if `sel` is the highest enabled index in `ch_en`, sampled that cycle.
  - `cnt`==DWELL-1: `cnt`<=0 and `sel` <= next enabled index above `sel`, wrapping 3->0 and searching up to 4 positions.
    - If `sel` is the only enabled channel, it repeats.
    - If `ch_en`=0 at this point, go to IDLE with `busy`=0.
  - Otherwise: `cnt`<=`cnt`+1.
- `ch_en` changes take effect only at the next advance decision; the current dwell always completes unless `stop` is asserted.
- `start` while in SCAN is ignored.
- `sample_valid` and `frame_done` are 0 on every edge not listed above.
- Capture and advance on the same edge (SETTLE=DWELL-1) are legal. The capture uses the old `sel`, and `sample_ch` names the old channel.

## Timing

- All outputs are registered; none is combinational from inputs.
- Start latency: with `start` high in cycle 0, cycle 1 has `busy`=1, `sel`=first enabled channel and `cnt`=0.
- Capture: `y_in` is sampled during the cycle with `cnt`=SETTLE, i.e. SETTLE+1 cycles after `sel` changed. `sample_valid` is high in the following cycle.
- Per-channel period: DWELL cycles. Frame period: DWELL × (number of enabled channels).
- With DWELL=1 and SETTLE=0, `sel` changes every cycle and `sample_valid` is high continuously.
- Stop latency: with `stop` high in cycle n, `busy`=0 in cycle n+1.
- Asynchronous reset clears all outputs without waiting for a clock edge, including mid-dwell.

## Test plan

1. Reset: assert `rst` between edges -> all outputs 0 immediately. Release `rst`, 5 idle cycles -> `busy`=0, `sel`=0, no pulses.
2. Full scan, DWELL=4, SETTLE=1, `ch_en`=4'b1111, mux inputs a=0, b=1, c=1, d=1, start at cycle 0:
   - `sel` = 0,1,2,3,0 at cycles 1,5,9,13,17.
   - `sample_valid` pulses at cycles 3,7,11,15; `sample`=4'b1110 after cycle 15.
   - `frame_done` pulses at cycle 15 only, then repeats every 16 cycles.
3. Masked scan, `ch_en`=4'b1010: `sel` alternates 1,3 every 4 cycles and the frame is 8 cycles. `sample[0]` and `sample[2]` stay 0. `frame_done` accompanies the channel-3 capture.
4. Empty mask:
   - `start` with `ch_en`=0 -> `busy` stays 0.
   - Clear `ch_en` to 0 mid-dwell while scanning -> the current dwell completes, then `busy`=0.
5. Stop:
   - `stop` at `cnt`=0 -> `busy`=0 next cycle, no `sample_valid`, `sel` held.
   - `start` and `stop` in the same cycle from IDLE -> remains IDLE.
6. Mid-scan reset: assert `rst` at `cnt`=2 on channel 2 -> `sample`=0 and `sel`=0 immediately. After release, a new `start` restarts scanning from the lowest enabled channel.
